coprocessor: RTL and testbench
==============================

Name: coprocessor

Overview:
- AXI4-Stream render coprocessor.
- Accepts a fixed-length scene/camera configuration packet on a slave stream.
- Produces one 32x32 frame of 32-bit pixels, in raster order, on a master stream.
- This revision uses a deterministic stub renderer (seed plus pixel index) in place of the ray tracer. Its interface and framing are the final ones.

Parameters:
- DATA_W, 32, stream data width in bits.
- PAYLOAD_WORDS, 27, configuration words per scene packet.
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.

Ports:
- aclk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- s_axis_tready  out  1  coprocessor can accept a config word.
- s_axis_tdata  in  DATA_W  config word.
- s_axis_tlast  in  1  last config word of packet.
- s_axis_tvalid  in  1  config word valid.
- m_axis_tvalid  out  1  pixel word valid.
- m_axis_tdata  out  DATA_W  pixel word.
- m_axis_tlast  out  1  last pixel of frame.
- m_axis_tready  in  1  downstream accepts pixel.

Behaviour:
- Clocking and reset: one clock domain (aclk). resetn is asynchronous assert, synchronous release.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. Word counter=0, pixel index=0, seed=0, state=RECV.
- FSM states: RECV, SEED, SEND.
- RECV:
  - s_axis_tready=1, registered; it rises on the first clock edge after reset release.
  - Beat accepted when s_axis_tvalid & s_axis_tready.
  - Each accepted word is stored in cfg_mem[count], PAYLOAD_WORDS x DATA_W registers, kept for the future renderer.
  - Each accepted word is added into seed, modulo 2^DATA_W. Count increments.
  - On the PAYLOAD_WORDS-th accepted beat: go to SEED and drop s_axis_tready on the next edge.
  - Missing tlast on the final word is not an error. Beats with tvalid low are ignored and may have any number of gap cycles.
- SEED:
  - One cycle.
  - Loads m_axis_tdata=seed, m_axis_tvalid=1, index=0, m_axis_tlast=(IMG_W*IMG_H==1).
  - Goes to SEND.
- SEND:
  - m_axis_tdata = seed + index, modulo 2^DATA_W. index = y*IMG_W + x, range 0..IMG_W*IMG_H-1.
  - m_axis_tlast=1 only when index = IMG_W*IMG_H-1.
  - tvalid, tdata and tlast stay stable while tready is low; no combinational path from tready to tvalid.
  - On handshake with index below the last: index increments and the next pixel is presented on the next cycle (1 pixel/cycle at full throughput).
  - On handshake of the last pixel: m_axis_tvalid=0, m_axis_tlast=0, seed=0, count=0, state=RECV; s_axis_tready=1 on the next edge.
- Latency: first pixel valid 2 edges after the final config beat is accepted.
- Slave stream is never ready during SEED or SEND; no overlap of receive and render.
- Reset asserted mid-packet or mid-frame: the partial packet/frame is abandoned and all outputs return to reset values immediately.
- s_axis_tdata content is not range-checked.

Optional Feature:
- Macro: COPROC_EARLY_TLAST_ABORT_EN.
- Defined: an accepted beat with s_axis_tlast=1 and count < PAYLOAD_WORDS-1 discards the packet. count=0, seed=0, stay in RECV, no frame produced.
- Not defined: s_axis_tlast is ignored entirely. Framing is by word count only.

Test Plan:
- Basic frame:
  - Stimulus: config words 1..27 with tlast on word 27; m_axis_tready held 1.
  - Expected: seed 0x17A; 1024 pixels 0x0000017A..0x00000579 in order; tlast only on 0x00000579; s_axis_tready returns to 1 afterwards.
- Back-pressure:
  - Stimulus: same packet; m_axis_tready toggled 1/0 pseudo-randomly.
  - Expected: identical 1024-word sequence; tdata/tlast stable while stalled; no word dropped or duplicated.
- Input gaps:
  - Stimulus: config words all 0xFFFFFFFF with tvalid low every other cycle.
  - Expected: seed 0xFFFFFFE5 (27 x 0xFFFFFFFF mod 2^32); pixel 27 = 0x00000000 (wrap); last pixel 0x000003E4.
- Reset mid-frame:
  - Stimulus: assert resetn=0 after 100 pixels are sent, release, send packet of 27 words of 0x00000002.
  - Expected: outputs zero during reset; new frame starts 0x00000036 and ends 0x00000435 with tlast.
- Early tlast:
  - Stimulus: 5 words with tlast on word 5, then a full 27-word packet 1..27.
  - With COPROC_EARLY_TLAST_ABORT_EN: single frame, seed 0x17A.
  - Without the macro: frame seed is the sum of the first 27 accepted words.
- Back-to-back frames:
  - Stimulus: two packets of 1..27 and all-zero.
  - Expected: frame 1 starts 0x17A; frame 2 starts 0x00000000 and ends 0x000003FF; tlast exactly once per frame.

Source files
------------

// File: rtl/coprocessor.sv
// AXI4-Stream render coprocessor: collects a scene packet, then streams one IMG_W x IMG_H frame.
// Optional build macro COPROC_EARLY_TLAST_ABORT_EN discards packets whose tlast arrives early.
module coprocessor #(
    parameter int DATA_W        = 32,
    parameter int PAYLOAD_WORDS = 27,
    parameter int IMG_W         = 32,
    parameter int IMG_H         = 32
) (
    input  logic              aclk,
    input  logic              resetn,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);

    localparam logic [1:0] ST_RECV = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // Stub renderer: pixel value is the packet checksum offset by the raster index.
    function automatic logic [DATA_W-1:0] pixel_of(input logic [DATA_W-1:0] seed,
                                                   input logic [IDX_W-1:0]  idx);
        return seed + DATA_W'(idx);
    endfunction

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DATA_W-1:0] seed_q,     seed_d;
    logic              s_tready_q, s_tready_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0] m_tdata_q,  m_tdata_d;
    logic              m_tlast_q,  m_tlast_d;
    logic              cfg_we;
    logic [IDX_W-1:0]  idx_nxt;

    logic [DATA_W-1:0] cfg_mem_q [PAYLOAD_WORDS];

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        seed_d     = seed_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        cfg_we     = 1'b0;
        idx_nxt    = idx_q + 1'b1;

        case (state_q)
            ST_RECV: begin
                s_tready_d = 1'b1;
                if (s_axis_tvalid && s_tready_q) begin
                    cfg_we  = 1'b1;
                    seed_d  = seed_q + s_axis_tdata;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d    = ST_SEED;
                        s_tready_d = 1'b0;
                    end
`ifdef COPROC_EARLY_TLAST_ABORT_EN
                    else if (s_axis_tlast) begin
                        count_d = '0;
                        seed_d  = '0;
                    end
`endif
                end
            end
            ST_SEED: begin
                m_tdata_d  = seed_q;
                m_tvalid_d = 1'b1;
                idx_d      = '0;
                m_tlast_d  = (NPIX == 1);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (m_axis_tready && m_tvalid_q) begin
                    if (idx_q == LAST_IDX) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        seed_d     = '0;
                        count_d    = '0;
                        s_tready_d = 1'b1;
                        state_d    = ST_RECV;
                    end else begin
                        idx_d     = idx_nxt;
                        m_tdata_d = pixel_of(seed_q, idx_nxt);
                        m_tlast_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RECV;
            count_q    <= '0;
            idx_q      <= '0;
            seed_q     <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            seed_q     <= seed_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    // Scene words are held for the future renderer; no reset needed on pure storage.
    always_ff @(posedge aclk) begin
        if (cfg_we) cfg_mem_q[count_q] <= s_axis_tdata;
    end

    // Nothing consumes the stored scene or tlast yet in the stub renderer.
    logic unused_cfg;
    always_comb begin
        unused_cfg = s_axis_tlast;
        for (int i = 0; i < PAYLOAD_WORDS; i++) unused_cfg = unused_cfg ^ (^cfg_mem_q[i]);
    end

endmodule

// File: tb/tb_coprocessor.sv
// Directed bench for coprocessor: packet framing, pixel sequence, back-pressure, reset, early tlast.
module tb_coprocessor;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    int n_vec = 0;
    int n_err = 0;

    coprocessor dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int mode, input int i);
        case (mode)
            0:       return 32'(i + 1);
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0002;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic send_words(input int n, input int mode, input bit gap, input int tlast_at);
        int  i   = 0;
        int  cyc = 0;
        bit  ph  = 1'b0;
        while (i < n && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            if (gap && ph) begin
                s_axis_tvalid = 1'b0;
                ph = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = word_of(mode, i);
                s_axis_tlast  = (i == tlast_at - 1);
                if (s_axis_tready) begin
                    i++;
                    ph = 1'b1;
                end
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (i < n) check("snd_timeout", 32'(i), 32'(n));
    endtask

    task automatic recv_frame(input logic [31:0] seed, input int npix, input bit bp);
        int          n       = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        logic [31:0] pd      = '0;
        logic        pl      = 1'b0;
        while (n < npix && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("stall_vld",  32'(m_axis_tvalid), 32'd1);
                check("stall_data", m_axis_tdata, pd);
                check("stall_last", 32'(m_axis_tlast), 32'(pl));
            end
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    check("pix_data", m_axis_tdata, seed + 32'(n));
                    check("pix_last", 32'(m_axis_tlast), 32'(n == 1023));
                    check("s_rdy_low", 32'(s_axis_tready), 32'd0);
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = m_axis_tdata;
                    pl = m_axis_tlast;
                end
            end
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        if (n < npix) check("rcv_timeout", 32'(n), 32'(npix));
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        resetn = 1'b0;
        #1;
        check("rst_s_rdy", 32'(s_axis_tready), 32'd0);
        check("rst_m_vld", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_data", m_axis_tdata, 32'd0);
        check("rst_m_last", 32'(m_axis_tlast), 32'd0);
        repeat (3) @(negedge aclk);
        resetn = 1'b1;
        @(negedge aclk);
        check("rdy_after_rst", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic check_idle();
        @(negedge aclk);
        check("idle_s_rdy", 32'(s_axis_tready), 32'd1);
        check("idle_m_vld", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        apply_reset();

        // basic frame
        fork
            send_words(27, 0, 1'b0, 27);
            recv_frame(32'h0000_017A, 1024, 1'b0);
        join
        check_idle();

        // back-pressure
        fork
            send_words(27, 0, 1'b0, 27);
            recv_frame(32'h0000_017A, 1024, 1'b1);
        join
        check_idle();

        // input gaps with wrapping seed
        fork
            send_words(27, 1, 1'b1, 27);
            recv_frame(32'hFFFF_FFE5, 1024, 1'b0);
        join
        check_idle();

        // reset mid-frame, then a fresh packet
        fork
            send_words(27, 0, 1'b0, 27);
            recv_frame(32'h0000_017A, 100, 1'b0);
        join
        apply_reset();
        fork
            send_words(27, 2, 1'b0, 27);
            recv_frame(32'h0000_0036, 1024, 1'b0);
        join
        check_idle();

        // back-to-back frames
        fork
            begin
                send_words(27, 0, 1'b0, 27);
                send_words(27, 3, 1'b0, 27);
            end
            begin
                recv_frame(32'h0000_017A, 1024, 1'b0);
                recv_frame(32'h0000_0000, 1024, 1'b1);
            end
        join
        check_idle();

        // early tlast
        fork
            begin
                send_words(5, 0, 1'b0, 5);
                send_words(27, 0, 1'b0, 27);
            end
`ifdef COPROC_EARLY_TLAST_ABORT_EN
            recv_frame(32'h0000_017A, 1024, 1'b0);
`else
            recv_frame(32'h0000_010C, 1024, 1'b0);
`endif
        join
        repeat (4) @(negedge aclk);
        check("early_no_extra", 32'(m_axis_tvalid), 32'd0);
        apply_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
